// File: rtl/mem_arbiter_if.sv
// Request, response and RAM-side signals of mem_arbiter grouped into one bundle.
// slave: arbiter side; master: requesters plus RAM (environment side).
interface mem_arbiter_if #(
  parameter int CPU_WIDTH = 32,
  parameter int RAM_AW    = 10
);
  logic                   if_req;
  logic [CPU_WIDTH-1:0]   if_addr;
  logic                   if_gnt;
  logic                   if_rvalid;
  logic                   if_err;
  logic [CPU_WIDTH-1:0]   if_rdata;

  logic                   dm_req;
  logic                   dm_we;
  logic [CPU_WIDTH-1:0]   dm_addr;
  logic [CPU_WIDTH-1:0]   dm_wdata;
  logic [CPU_WIDTH/8-1:0] dm_be;
  logic                   dm_gnt;
  logic                   dm_rvalid;
  logic                   dm_err;
  logic [CPU_WIDTH-1:0]   dm_rdata;

  logic                   mem_en;
  logic                   mem_we;
  logic [RAM_AW-1:0]      mem_addr;
  logic [CPU_WIDTH-1:0]   mem_wdata;
  logic [CPU_WIDTH/8-1:0] mem_be;
  logic [CPU_WIDTH-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
    output if_gnt, if_rvalid, if_err, if_rdata,
           dm_gnt, dm_rvalid, dm_err, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
    input  if_gnt, if_rvalid, if_err, if_rdata,
           dm_gnt, dm_rvalid, dm_err, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_arbiter.sv
// Instruction-fetch / data arbiter in front of a single-port synchronous RAM.
// Define MEM_ARB_RR_EN for round-robin contention; otherwise the data port has fixed priority.
module mem_arbiter #(
  parameter int CPU_WIDTH = 32,
  parameter int RAM_AW    = 10
) (
  input  logic         clk,
  input  logic         a_reset_n,
  mem_arbiter_if.slave bus
);
  localparam int         BE_W     = CPU_WIDTH / 8;
  localparam logic [0:0] OWNER_IF = 1'b0;
  localparam logic [0:0] OWNER_DM = 1'b1;

  // Misaligned or beyond the RAM window: answered with err instead of touching the RAM.
  function automatic logic addr_bad(input logic [CPU_WIDTH-1:0] addr);
    logic [CPU_WIDTH-1:0] high_s;
    high_s = addr >> (RAM_AW + 2);
    return (addr[1:0] != 2'b00) || (high_s != {CPU_WIDTH{1'b0}});
  endfunction

  logic [0:0]           last_owner_q, last_owner_d;
  logic [0:0]           rsp_owner_q, rsp_owner_d;
  logic                 rsp_pending_q, rsp_pending_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_we_q, rsp_we_d;

  logic                 any_req_s;
  logic                 sel_dm_s;
  logic [CPU_WIDTH-1:0] sel_addr_s;
  logic                 addr_err_s;
  logic                 acc_ok_s;
  logic                 wr_s;
  logic                 if_rsp_s;
  logic                 dm_rsp_s;

  // Arbitration: pick one requester and qualify its address.
  always_comb begin
    any_req_s = a_reset_n & (bus.if_req | bus.dm_req);
`ifdef MEM_ARB_RR_EN
    if (bus.if_req && bus.dm_req) begin
      sel_dm_s = (last_owner_q == OWNER_IF);
    end else begin
      sel_dm_s = bus.dm_req;
    end
`else
    sel_dm_s = bus.dm_req;
`endif
    if (sel_dm_s) begin
      sel_addr_s = bus.dm_addr;
    end else begin
      sel_addr_s = bus.if_addr;
    end
    addr_err_s = addr_bad(sel_addr_s);
    acc_ok_s   = any_req_s & ~addr_err_s;
    wr_s       = acc_ok_s & sel_dm_s & bus.dm_we;
  end

  // Grant pulses and RAM strobes for the access issued this cycle.
  always_comb begin
    bus.if_gnt = any_req_s & ~sel_dm_s;
    bus.dm_gnt = any_req_s & sel_dm_s;
    bus.mem_en = acc_ok_s;
    bus.mem_we = wr_s;
    if (acc_ok_s) begin
      bus.mem_addr = sel_addr_s[RAM_AW+1:2];
    end else begin
      bus.mem_addr = {RAM_AW{1'b0}};
    end
    if (wr_s) begin
      bus.mem_wdata = bus.dm_wdata;
      bus.mem_be    = bus.dm_be;
    end else begin
      bus.mem_wdata = {CPU_WIDTH{1'b0}};
      bus.mem_be    = {BE_W{1'b0}};
    end
  end

  // Response routing: RAM data is steered by the owner tag captured at grant time.
  always_comb begin
    if_rsp_s      = rsp_pending_q & (rsp_owner_q == OWNER_IF);
    dm_rsp_s      = rsp_pending_q & (rsp_owner_q == OWNER_DM);
    bus.if_rvalid = if_rsp_s & ~rsp_we_q;
    bus.if_err    = if_rsp_s & rsp_err_q;
    bus.dm_rvalid = dm_rsp_s & ~rsp_we_q;
    bus.dm_err    = dm_rsp_s & rsp_err_q;
    if (if_rsp_s && !rsp_we_q && !rsp_err_q) begin
      bus.if_rdata = bus.mem_rdata;
    end else begin
      bus.if_rdata = {CPU_WIDTH{1'b0}};
    end
    if (dm_rsp_s && !rsp_we_q && !rsp_err_q) begin
      bus.dm_rdata = bus.mem_rdata;
    end else begin
      bus.dm_rdata = {CPU_WIDTH{1'b0}};
    end
  end

  // Next-state of the response tag and owner history.
  always_comb begin
    rsp_pending_d = any_req_s;
    rsp_err_d     = any_req_s & addr_err_s;
    rsp_we_d      = any_req_s & sel_dm_s & bus.dm_we;
    if (sel_dm_s) begin
      rsp_owner_d = OWNER_DM;
    end else begin
      rsp_owner_d = OWNER_IF;
    end
    if (any_req_s) begin
      last_owner_d = rsp_owner_d;
    end else begin
      last_owner_d = last_owner_q;
    end
  end

  // State registers; reset drops any in-flight response.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      last_owner_q  <= OWNER_DM;
      rsp_owner_q   <= OWNER_IF;
      rsp_pending_q <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_we_q      <= 1'b0;
    end else begin
      last_owner_q  <= last_owner_d;
      rsp_owner_q   <= rsp_owner_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_err_q     <= rsp_err_d;
      rsp_we_q      <= rsp_we_d;
    end
  end
endmodule
